// File: rtl/cache_line_mover_if.sv
// Bundle of request, data-array and physical-memory signals between the line mover and its neighbours.
// The master modport is the mover itself; the slave modport is its surroundings.
interface cache_line_mover_if #(
  parameter int WIDTH    = 128,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = 9
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  logic               req_valid;
  logic               req_ready;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               req_dirty;
  logic [TAG_W-1:0]   req_vtag;
  logic               done;

  logic [INDEX_W-1:0] arr_index;
  logic               arr_write;
  logic [WIDTH-1:0]   arr_wdata;
  logic [WIDTH-1:0]   arr_rdata;

  logic [ADDR_W-1:0]  pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [WIDTH-1:0]   pmem_wdata;
  logic [WIDTH-1:0]   pmem_rdata;
  logic               pmem_resp;

  modport master (
    input  req_valid, req_index, req_tag, req_dirty, req_vtag,
    input  arr_rdata, pmem_rdata, pmem_resp,
    output req_ready, done, arr_index, arr_write, arr_wdata,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport slave (
    output req_valid, req_index, req_tag, req_dirty, req_vtag,
    output arr_rdata, pmem_rdata, pmem_resp,
    input  req_ready, done, arr_index, arr_write, arr_wdata,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/cache_line_mover.sv
// Cache line transfer engine: optional dirty-victim writeback to pmem, then line fill
// from pmem installed into the data array. One transfer in flight at a time.
module cache_line_mover #(
  parameter int WIDTH    = 128,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  cache_line_mover_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB      = 2'd1,
    S_FILL    = 2'd2,
    S_INSTALL = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_vtag;
  logic [WIDTH-1:0]   r_wb_buf;
  logic [WIDTH-1:0]   r_fill_buf;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Victim data is captured on accept so the array is free for the later install.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index    <= '0;
      r_tag      <= '0;
      r_vtag     <= '0;
      r_wb_buf   <= '0;
      r_fill_buf <= '0;
    end else begin
      if (w_accept) begin
        r_index  <= bus.req_index;
        r_tag    <= bus.req_tag;
        r_vtag   <= bus.req_vtag;
        r_wb_buf <= bus.arr_rdata;
      end
      if ((r_state == S_FILL) && bus.pmem_resp) begin
        r_fill_buf <= bus.pmem_rdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.req_valid) w_next = bus.req_dirty ? S_WB : S_FILL;
      S_WB:      if (bus.pmem_resp) w_next = S_FILL;
      S_FILL:    if (bus.pmem_resp) w_next = S_INSTALL;
      S_INSTALL: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes are pure decodes of the state register, so reset drops them immediately.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.done         = 1'b0;
    bus.arr_index    = r_index;
    bus.arr_write    = 1'b0;
    bus.arr_wdata    = '0;
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.arr_index = bus.req_index;
      end
      S_WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {r_vtag, r_index, {OFFSET_W{1'b0}}};
        bus.pmem_wdata   = r_wb_buf;
      end
      S_FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {r_tag, r_index, {OFFSET_W{1'b0}}};
      end
      S_INSTALL: begin
        bus.arr_write = 1'b1;
        bus.arr_wdata = r_fill_buf;
        bus.done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// Testbench for cache_line_mover: transaction-level reference model with per-cycle
// comparison, directed scenarios, and randomized miss traffic with random pmem latency.
module tb_cache_line_mover;
  localparam int WIDTH    = 128;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_mover_if #(.WIDTH(WIDTH), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) bus ();

  cache_line_mover #(.WIDTH(WIDTH), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic to_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout, got no event want event", name);
  endtask

  function automatic logic [WIDTH-1:0] init_val(input int i);
    if (i == 5) return {32{4'hA}};
    return {4{i[7:0], 24'h5A5A5A}};
  endfunction

  // Data array environment: combinational read, write on clock edge
  logic [WIDTH-1:0] tb_arr [8];
  logic load_arr = 1'b1;
  assign bus.arr_rdata = tb_arr[bus.arr_index];
  always @(posedge clk) begin
    if (load_arr) begin
      for (int i = 0; i < 8; i++) tb_arr[i] <= init_val(i);
    end else if (bus.arr_write) begin
      tb_arr[bus.arr_index] <= bus.arr_wdata;
    end
  end

  // pmem responder: 0 random, 1 always respond, 2 respond on 4th strobe cycle, 3 never
  int pmode = 3;
  bit rdata_fixed = 1'b0;
  logic [WIDTH-1:0] rdata_pat = '0;
  initial begin
    int age;
    age = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!(bus.pmem_read || bus.pmem_write)) age = 0;
      else if (bus.pmem_resp) age = 1;
      else age++;
      case (pmode)
        1:       bus.pmem_resp = 1'b1;
        2:       bus.pmem_resp = (age >= 4);
        3:       bus.pmem_resp = 1'b0;
        default: bus.pmem_resp = ($urandom_range(0, 2) == 0);
      endcase
      bus.pmem_rdata = rdata_fixed ? rdata_pat : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Reference model: pending writeback / fill / install of the one outstanding miss
  logic [WIDTH-1:0]   ref_arr [8];
  bit                 busy = 1'b0;
  bit                 wb_p, fill_p;
  logic [INDEX_W-1:0] m_idx;
  logic [TAG_W-1:0]   m_tag, m_vtag;
  logic [WIDTH-1:0]   m_wb, m_fill;
  int                 n_wr_cyc = 0, n_rd_cyc = 0, n_done = 0;
  logic [15:0]        last_rd_addr = '0, last_wr_addr = '0;
  logic [WIDTH-1:0]   last_wr_data = '0;

  always @(negedge clk) begin
    chk("strobe_overlap", WIDTH'(bus.pmem_read && bus.pmem_write), '0);
    if (!reset_n) begin
      if (load_arr) for (int i = 0; i < 8; i++) ref_arr[i] = init_val(i);
      busy = 1'b0;
      chk("rst_ready", WIDTH'(bus.req_ready), 1);
      chk("rst_pmem_read", WIDTH'(bus.pmem_read), 0);
      chk("rst_pmem_write", WIDTH'(bus.pmem_write), 0);
      chk("rst_arr_write", WIDTH'(bus.arr_write), 0);
      chk("rst_done", WIDTH'(bus.done), 0);
    end else begin
      if (bus.pmem_write) begin
        n_wr_cyc++;
        last_wr_addr = bus.pmem_address;
        last_wr_data = bus.pmem_wdata;
      end
      if (bus.pmem_read) begin
        n_rd_cyc++;
        last_rd_addr = bus.pmem_address;
      end
      if (bus.done) n_done++;
      if (!busy) begin
        chk("idle_ready", WIDTH'(bus.req_ready), 1);
        chk("idle_arr_index", WIDTH'(bus.arr_index), WIDTH'(bus.req_index));
        chk("idle_pmem_read", WIDTH'(bus.pmem_read), 0);
        chk("idle_pmem_write", WIDTH'(bus.pmem_write), 0);
        chk("idle_arr_write", WIDTH'(bus.arr_write), 0);
        chk("idle_done", WIDTH'(bus.done), 0);
        if (bus.req_valid) begin
          busy   = 1'b1;
          m_idx  = bus.req_index;
          m_tag  = bus.req_tag;
          m_vtag = bus.req_vtag;
          m_wb   = ref_arr[bus.req_index];
          wb_p   = bus.req_dirty;
          fill_p = 1'b1;
        end
      end else begin
        chk("busy_ready", WIDTH'(bus.req_ready), 0);
        chk("busy_arr_index", WIDTH'(bus.arr_index), WIDTH'(m_idx));
        if (wb_p) begin
          chk("wb_write", WIDTH'(bus.pmem_write), 1);
          chk("wb_read", WIDTH'(bus.pmem_read), 0);
          chk("wb_addr", WIDTH'(bus.pmem_address), WIDTH'({m_vtag, m_idx, 4'h0}));
          chk("wb_data", bus.pmem_wdata, m_wb);
          chk("wb_arr_write", WIDTH'(bus.arr_write), 0);
          if (bus.pmem_resp) wb_p = 1'b0;
        end else if (fill_p) begin
          chk("fill_read", WIDTH'(bus.pmem_read), 1);
          chk("fill_write", WIDTH'(bus.pmem_write), 0);
          chk("fill_addr", WIDTH'(bus.pmem_address), WIDTH'({m_tag, m_idx, 4'h0}));
          chk("fill_arr_write", WIDTH'(bus.arr_write), 0);
          chk("fill_done", WIDTH'(bus.done), 0);
          if (bus.pmem_resp) begin
            m_fill = bus.pmem_rdata;
            fill_p = 1'b0;
          end
        end else begin
          chk("inst_arr_write", WIDTH'(bus.arr_write), 1);
          chk("inst_done", WIDTH'(bus.done), 1);
          chk("inst_wdata", bus.arr_wdata, m_fill);
          chk("inst_read", WIDTH'(bus.pmem_read), 0);
          chk("inst_write", WIDTH'(bus.pmem_write), 0);
          ref_arr[m_idx] = m_fill;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic drive_req(input int idx, input int tag, input int vtag, input bit dirty);
    bus.req_index = INDEX_W'(idx);
    bus.req_tag   = TAG_W'(tag);
    bus.req_vtag  = TAG_W'(vtag);
    bus.req_dirty = dirty;
    bus.req_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.req_ready && bus.req_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_fail(name);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_fail(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    pmode = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr0, rd0, dn0, cyc;
    bit got;
    bus.req_valid = 1'b0;
    bus.req_index = '0;
    bus.req_tag   = '0;
    bus.req_vtag  = '0;
    bus.req_dirty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    load_arr = 1'b0;
    chk("reset_req_ready", WIDTH'(bus.req_ready), 1);
    chk("reset_done", WIDTH'(bus.done), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean miss, fill response on 4th cycle of the read strobe
    rdata_fixed = 1'b1;
    rdata_pat = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    set_mode(2);
    wr0 = n_wr_cyc; dn0 = n_done; rd0 = n_rd_cyc;
    drive_req(3, 'h1A5, 'h000, 1'b0);
    wait_accept("clean_accept");
    bus.req_valid = 1'b0;
    wait_done("clean_done");
    repeat (3) @(posedge clk);
    #1;
    chk("clean_rd_addr", WIDTH'(last_rd_addr), WIDTH'(16'hD2B0));
    chk("clean_rd_cycles", WIDTH'(n_rd_cyc - rd0), 4);
    chk("clean_no_write", WIDTH'(n_wr_cyc - wr0), 0);
    chk("clean_done_once", WIDTH'(n_done - dn0), 1);
    chk("clean_arr3", tb_arr[3], 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

    // Dirty miss: writeback of the victim in line 5, then fill
    rdata_pat = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    drive_req(5, 'h0F0, 'h011, 1'b1);
    wait_accept("dirty_accept");
    bus.req_valid = 1'b0;
    wait_done("dirty_done");
    chk("dirty_wr_addr", WIDTH'(last_wr_addr), WIDTH'(16'h08D0));
    chk("dirty_wr_data", last_wr_data, {32{4'hA}});
    chk("dirty_rd_addr", WIDTH'(last_rd_addr), WIDTH'(16'h7850));
    chk("dirty_arr5", tb_arr[5], 128'h01234567_89ABCDEF_FEDCBA98_76543210);

    // Back-to-back with req_valid held high
    rdata_fixed = 1'b0;
    set_mode(0);
    dn0 = n_done;
    drive_req(1, 'h0AB, 'h1CD, 1'b1);
    wait_accept("b2b_accept1");
    drive_req(7, 'h123, 'h045, 1'b0);
    wait_accept("b2b_accept2");
    chk("b2b_done_between", WIDTH'(n_done - dn0), 1);
    bus.req_valid = 1'b0;
    wait_done("b2b_done2");

    // Stray responses while idle
    set_mode(1);
    dn0 = n_done; wr0 = n_wr_cyc; rd0 = n_rd_cyc;
    repeat (6) @(posedge clk);
    #1;
    chk("stray_no_done", WIDTH'(n_done - dn0), 0);
    chk("stray_no_strobe", WIDTH'((n_wr_cyc - wr0) + (n_rd_cyc - rd0)), 0);

    // Zero-wait pmem: dirty miss done on the 4th cycle counting the accept
    drive_req(2, 'h155, 'h0AA, 1'b1);
    @(negedge clk);
    cyc = 1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_fail("zero_wait_done");
    else chk("zero_wait_latency", WIDTH'(cyc), 4);
    @(posedge clk);
    #1;

    // Reset while writeback is outstanding
    set_mode(3);
    drive_req(6, 'h0C3, 'h13C, 1'b1);
    wait_accept("rst_wb_accept");
    bus.req_valid = 1'b0;
    chk("rst_wb_in_wb", WIDTH'(bus.pmem_write), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_wb_write_drop", WIDTH'(bus.pmem_write), 0);
    chk("rst_wb_no_arr_write", WIDTH'(bus.arr_write), 0);
    chk("rst_wb_ready", WIDTH'(bus.req_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_wb_arr6_kept", tb_arr[6], init_val(6));
    set_mode(0);
    drive_req(6, 'h0C3, 'h13C, 1'b1);
    wait_accept("rst_wb_accept2");
    bus.req_valid = 1'b0;
    wait_done("rst_wb_done2");

    // Randomized miss traffic
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      drive_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      wait_accept("rand_accept");
      bus.req_valid = 1'b0;
    end
    wait_done("rand_final_done");
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) chk("final_array", tb_arr[i], ref_arr[i]);
    chk("final_idle", WIDTH'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end
endmodule
